game_ctl: RTL and testbench

//  Pong game sequencer. Decides when the ball is held, served or moving. Counts paddle hits

---
 rtl/game_ctl.sv | 155 +++++++++++++++
 tb/tb_game_ctl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/game_ctl.sv
// Pong game sequencer: holds, serves and runs the ball frame by frame, and
// keeps score, speed level and lives for ball_ctl and the overlay.
module game_ctl #(
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int LIVES        = 3,
  parameter int MISS_X       = 16,
  parameter int HITS_PER_LVL = 5,
  parameter int MAX_LEVEL    = 7,
  parameter int SCORE_MAX    = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [10:0] ball_xpos,
  input  logic        paddle_hit,
  output logic        ball_hold,
  output logic        ball_en,
  output logic [2:0]  level,
  output logic [9:0]  score,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int FMAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CW   = $clog2(FMAX + 1);
  localparam int HW   = $clog2(HITS_PER_LVL + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    score_q, score_d;
  logic [2:0]    level_q, level_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [2:0]    lives_q, lives_d;
  logic          vsync_q, btn_q, arm_q;
  logic          btn_any, frame_tick, start;

  assign btn_any    = btn_up | btn_down;
  assign frame_tick = vsync & ~vsync_q;
  // arm_q stays low out of reset until the buttons are seen released, so a
  // button held across reset cannot start a game.
  assign start      = btn_any & ~btn_q & arm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      level_q <= '0;
      hits_q  <= '0;
      lives_q <= 3'(LIVES);
      vsync_q <= 1'b0;
      btn_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      level_q <= level_d;
      hits_q  <= hits_d;
      lives_q <= lives_d;
      vsync_q <= vsync;
      btn_q   <= btn_any;
      arm_q   <= arm_q | ~btn_any;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    level_d = level_q;
    hits_d  = hits_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_SERVE;
          cnt_d   = '0;
          score_d = '0;
          level_d = '0;
          hits_d  = '0;
          lives_d = 3'(LIVES);
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // a miss in the same cycle as a bounce wins; the hit is dropped
        if (ball_xpos < 11'(MISS_X)) begin
          state_d = S_MISS;
          cnt_d   = '0;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end else if (paddle_hit) begin
          if (score_q != 10'(SCORE_MAX)) score_d = score_q + 10'd1;
          if (hits_q == HW'(HITS_PER_LVL - 1)) begin
            hits_d = '0;
            if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
          end else begin
            hits_d = hits_q + 1'b1;
          end
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (cnt_q == CW'(MISS_FRAMES - 1)) begin
            state_d = (lives_q == 3'd0) ? S_OVER : S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ball_hold = 1'b1;
    ball_en   = 1'b0;
    game_over = 1'b0;
    case (state_q)
      S_PLAY: begin
        ball_hold = 1'b0;
        ball_en   = 1'b1;
      end
      S_MISS:  ball_hold = 1'b0;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign level   = level_q;
  assign score   = score_q;
  assign lives   = lives_q;

endmodule

// File: tb/tb_game_ctl.sv
// Scoreboard bench for game_ctl: expected snapshots are queued as stimulus is
// driven and compared one clock later against the packed output vector.
module tb_game_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0, btn_up = 1'b0, btn_down = 1'b0, paddle_hit = 1'b0;
  logic [10:0] ball_xpos = 11'd400;
  logic        ball_hold, ball_en, game_over;
  logic [2:0]  level, lives, state_o;
  logic [9:0]  score;

  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4;

  game_ctl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_up(btn_up), .btn_down(btn_down),
    .ball_xpos(ball_xpos), .paddle_hit(paddle_hit), .ball_hold(ball_hold),
    .ball_en(ball_en), .level(level), .score(score), .lives(lives),
    .game_over(game_over), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [21:0] obs;
  assign obs = {state_o, ball_hold, ball_en, game_over, level, score, lives};

  // expected output vector; hold/en/over follow from the state alone
  function automatic logic [21:0] mk(input logic [2:0] st, input logic [2:0] lvl,
                                     input logic [9:0] sc, input logic [2:0] lv);
    logic h, e, o;
    h = (st == IDLE) || (st == SERVE) || (st == OVER);
    e = (st == PLAY);
    o = (st == OVER);
    return {st, h, e, o, lvl, sc, lv};
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d hold=%b en=%b over=%b lvl=%0d score=%0d lives=%0d, want st=%0d hold=%b en=%b over=%b lvl=%0d score=%0d lives=%0d",
               tag, got[21:19], got[18], got[17], got[16], got[15:13], got[12:3], got[2:0],
               exp[21:19], exp[18], exp[17], exp[16], exp[15:13], exp[12:3], exp[2:0]);
    end
  endtask

  task automatic push(input string tag, input logic [21:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.v);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; step();
      vsync = 1'b0; step();
    end
  endtask

  task automatic serve_to_play(input string tag, input logic [2:0] lvl,
                               input logic [9:0] sc, input logic [2:0] lv);
    pulses(SERVE_N - 1);
    push({tag, "_serve59"}, mk(SERVE, lvl, sc, lv)); step();
    vsync = 1'b1;
    push({tag, "_play"}, mk(PLAY, lvl, sc, lv)); step();
    vsync = 1'b0; step();
  endtask

  task automatic miss_wait(input string tag, input logic [2:0] nxt, input logic [2:0] lvl,
                           input logic [9:0] sc, input logic [2:0] lv);
    pulses(MISS_N - 1);
    push({tag, "_miss89"}, mk(MISS, lvl, sc, lv)); step();
    vsync = 1'b1;
    push({tag, "_after"}, mk(nxt, lvl, sc, lv)); step();
    vsync = 1'b0; step();
  endtask

  task automatic hit(input string tag, input logic [21:0] v, input logic chk);
    paddle_hit = 1'b1;
    if (chk) push(tag, v);
    step();
    paddle_hit = 1'b0;
  endtask

  localparam int SERVE_N = 60;
  localparam int MISS_N  = 90;

  initial begin
    // 1: reset with a button held, then a fresh edge starts the game
    btn_up = 1'b1;
    push("reset", mk(IDLE, 3'd0, 10'd0, 3'd3)); step();
    step();
    rst = 1'b1;
    step(); step();
    push("held_through_reset", mk(IDLE, 3'd0, 10'd0, 3'd3)); step();
    btn_up = 1'b0; step();
    btn_up = 1'b1;
    push("start", mk(SERVE, 3'd0, 10'd0, 3'd3)); step();

    // 2: serve timing
    serve_to_play("serve1", 3'd0, 10'd0, 3'd3);

    // 3: hits, level stepping and saturation; button edge ignored in PLAY
    for (int i = 1; i <= 3; i++) hit("", '0, 1'b0);
    hit("hit4", mk(PLAY, 3'd0, 10'd4, 3'd3), 1'b1);
    hit("hit5", mk(PLAY, 3'd1, 10'd5, 3'd3), 1'b1);
    for (int i = 6; i <= 34; i++) hit("", '0, 1'b0);
    hit("hit35", mk(PLAY, 3'd7, 10'd35, 3'd3), 1'b1);
    for (int i = 36; i <= 44; i++) hit("", '0, 1'b0);
    hit("hit45", mk(PLAY, 3'd7, 10'd45, 3'd3), 1'b1);
    btn_up = 1'b0; step();
    btn_up = 1'b1;
    push("start_in_play", mk(PLAY, 3'd7, 10'd45, 3'd3)); step();

    // 4: miss with simultaneous hit; miss pause back to serve
    ball_xpos = 11'd10;
    hit("miss_and_hit", mk(MISS, 3'd7, 10'd45, 3'd2), 1'b1);
    ball_xpos = 11'd400;
    hit("hit_in_miss", mk(MISS, 3'd7, 10'd45, 3'd2), 1'b1);
    miss_wait("miss1", SERVE, 3'd7, 10'd45, 3'd2);

    // 5: remaining lives lost -> OVER, then restart
    serve_to_play("serve2", 3'd7, 10'd45, 3'd2);
    ball_xpos = 11'd15;
    push("miss2", mk(MISS, 3'd7, 10'd45, 3'd1)); step();
    ball_xpos = 11'd400;
    miss_wait("wait2", SERVE, 3'd7, 10'd45, 3'd1);
    serve_to_play("serve3", 3'd7, 10'd45, 3'd1);
    ball_xpos = 11'd0;
    push("miss3", mk(MISS, 3'd7, 10'd45, 3'd0)); step();
    ball_xpos = 11'd400;
    miss_wait("wait3", OVER, 3'd7, 10'd45, 3'd0);
    hit("hit_in_over", mk(OVER, 3'd7, 10'd45, 3'd0), 1'b1);
    btn_up = 1'b0;
    push("over_release", mk(OVER, 3'd7, 10'd45, 3'd0)); step();
    btn_down = 1'b1; vsync = 1'b1;
    push("restart", mk(SERVE, 3'd0, 10'd0, 3'd3)); step();
    vsync = 1'b0; step();
    serve_to_play("serve4", 3'd0, 10'd0, 3'd3);

    // 6: miss boundary, score saturation, async reset mid-play
    ball_xpos = 11'd16;
    push("xpos16_no_miss", mk(PLAY, 3'd0, 10'd0, 3'd3)); step();
    ball_xpos = 11'd400;
    paddle_hit = 1'b1;
    for (int i = 1; i <= 998; i++) step();
    push("score999", mk(PLAY, 3'd7, 10'd999, 3'd3)); step();
    push("score_sat", mk(PLAY, 3'd7, 10'd999, 3'd3)); step();
    paddle_hit = 1'b0;
    rst = 1'b0;
    #2;
    check("async_reset", obs, mk(IDLE, 3'd0, 10'd0, 3'd3));
    push("in_reset", mk(IDLE, 3'd0, 10'd0, 3'd3)); step();

    if (exp_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_left: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
